// File: rtl/sdram_rd_arbiter.sv
// Shares the SDRAM controller read port between two requesters, one read in flight at a time.
// Round-robin or fixed-priority grant; a watchdog aborts a read whose ready never arrives.
module sdram_rd_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter bit RR      = 1'b1,
    parameter int TIMEOUT = 255
) (
    input  logic              sdram_clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic [DATA_W-1:0] dout,
    output logic              err,
    output logic              timeout_seen,
    output logic              sdram_rd,
    output logic [ADDR_W-1:0] sdram_raddr,
    input  logic              sdram_rd_rdy,
    input  logic [DATA_W-1:0] sdram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_sel;
    logic              r_last;
    logic              r_err;
    logic              r_timeout_seen;
    logic [9:0]        r_wdog;
    logic [ADDR_W-1:0] r_raddr;
    logic [DATA_W-1:0] r_dout;

    logic              w_grant_vld;
    logic              w_grant_port;
    logic              w_expired;
    logic              w_rd;
    logic              w_ack0;
    logic              w_ack1;
    logic              w_err;

    // With both ports requesting, round-robin hands the grant to the port that did not win last.
    always_comb begin
        w_grant_vld  = req0 | req1;
        w_grant_port = 1'b0;
        if (req0 && req1) begin
            w_grant_port = RR ? ~r_last : 1'b0;
        end else begin
            w_grant_port = req1;
        end
    end

    assign w_expired = (r_wdog == WDOG_LAST);

    // NOTE: every state and datapath register uses <= so all updates see pre-edge values.
    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: defaults are assigned first so no path through the case leaves an output unassigned.
    always_comb begin
        w_state_next = r_state;
        w_rd         = 1'b0;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_rd         = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (sdram_rd_rdy || w_expired) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_ack0       = ~r_sel;
                w_ack1       = r_sel;
                w_err        = r_err;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sdram_clk or posedge reset) begin
        if (reset) begin
            r_sel          <= 1'b0;
            r_last         <= 1'b1;
            r_err          <= 1'b0;
            r_timeout_seen <= 1'b0;
            r_wdog         <= '0;
            r_raddr        <= '0;
            r_dout         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_sel   <= w_grant_port;
                        r_raddr <= w_grant_port ? addr1 : addr0;
                        if (RR) begin
                            r_last <= w_grant_port;
                        end
                    end
                end
                ISSUE: begin
                    r_wdog <= '0;
                end
                WAIT: begin
                    r_wdog <= r_wdog + 10'd1;
                    // A ready landing on the expiry cycle still delivers its data.
                    if (sdram_rd_rdy) begin
                        r_dout <= sdram_dout;
                        r_err  <= 1'b0;
                    end else if (w_expired) begin
                        r_err          <= 1'b1;
                        r_timeout_seen <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ack0         = w_ack0;
    assign ack1         = w_ack1;
    assign err          = w_err;
    assign sdram_rd     = w_rd;
    assign sdram_raddr  = r_raddr;
    assign dout         = r_dout;
    assign timeout_seen = r_timeout_seen;

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Scoreboard bench for sdram_rd_arbiter: a transaction-level model predicts grant order, data,
// error and latency; a negedge monitor compares every strobe and ack against the queued predictions.
`timescale 1ns/1ps
module tb_sdram_rd_arbiter;

    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    typedef struct {
        bit                port;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dout;
        bit                err;
        bit                tseen;
        int                lat;
    } exp_t;

    typedef struct {
        int                k;
        bit                stray;
        bit                to;
        logic [DATA_W-1:0] data;
    } ctl_t;

    logic              sdram_clk = 1'b0;
    logic              reset = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic              ack0, ack1, err, timeout_seen, sdram_rd;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] sdram_raddr;
    logic              sdram_rd_rdy = 1'b0;
    logic [DATA_W-1:0] sdram_dout = '0;

    logic              fp_req0 = 1'b0, fp_req1 = 1'b0;
    logic [ADDR_W-1:0] fp_addr0 = '0, fp_addr1 = '0;
    logic              fp_ack0, fp_ack1, fp_err, fp_tseen, fp_sdram_rd;
    logic [DATA_W-1:0] fp_dout;
    logic [ADDR_W-1:0] fp_raddr;
    logic              fp_rdy = 1'b0;
    logic [DATA_W-1:0] fp_sd_dout = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t exp_q[$];
    ctl_t ctl_q[$];
    bit                in_flight = 1'b0;
    int                strobe_cyc = 0;
    int                rdy_at = -1;
    int                stray_at = -1;
    logic [DATA_W-1:0] rdy_data = '0;
    bit                drop0 = 1'b0, drop1 = 1'b0;

    bit                m_last = 1'b1;
    bit                m_tseen = 1'b0;
    logic [DATA_W-1:0] m_dout = '0;
    logic [DATA_W-1:0] hold_dout = '0;

    sdram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR(1'b1), .TIMEOUT(TIMEOUT)) u_dut (
        .sdram_clk(sdram_clk), .reset(reset),
        .req0(req0), .addr0(addr0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .ack1(ack1),
        .dout(dout), .err(err), .timeout_seen(timeout_seen),
        .sdram_rd(sdram_rd), .sdram_raddr(sdram_raddr),
        .sdram_rd_rdy(sdram_rd_rdy), .sdram_dout(sdram_dout)
    );

    sdram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR(1'b0), .TIMEOUT(TIMEOUT)) u_fp (
        .sdram_clk(sdram_clk), .reset(reset),
        .req0(fp_req0), .addr0(fp_addr0), .ack0(fp_ack0),
        .req1(fp_req1), .addr1(fp_addr1), .ack1(fp_ack1),
        .dout(fp_dout), .err(fp_err), .timeout_seen(fp_tseen),
        .sdram_rd(fp_sdram_rd), .sdram_raddr(fp_raddr),
        .sdram_rd_rdy(fp_rdy), .sdram_dout(fp_sd_dout)
    );

    always #5 sdram_clk = ~sdram_clk;
    always @(posedge sdram_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Model: predicts one transaction from the arbitration and watchdog rules.
    task automatic push_txn(input bit p, input logic [ADDR_W-1:0] a, input int k,
                            input logic [DATA_W-1:0] d, input bit s);
        exp_t e;
        ctl_t c;
        bit   to;
        to = (k == 0) || (k > TIMEOUT);
        if (!to) m_dout = d;
        if (to) m_tseen = 1'b1;
        e.port  = p;
        e.addr  = a;
        e.dout  = m_dout;
        e.err   = to;
        e.tseen = m_tseen;
        e.lat   = to ? TIMEOUT + 1 : k + 1;
        exp_q.push_back(e);
        c.k     = k;
        c.stray = s;
        c.to    = to;
        c.data  = d;
        ctl_q.push_back(c);
        m_last = p;
    endtask

    // mode 0: port 0 only, 1: port 1 only, 2: both ports at once.
    task automatic launch(input int mode, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                          input int ka, input int kb, input logic [DATA_W-1:0] da,
                          input logic [DATA_W-1:0] db, input bit sa, input bit sb);
        bit first;
        first = (mode == 2) ? ~m_last : (mode == 1);
        push_txn(first, first ? a1 : a0, ka, da, sa);
        if (mode == 2) push_txn(~first, first ? a0 : a1, kb, db, sb);
        addr0 = a0;
        addr1 = a1;
        if (mode != 1) req0 = 1'b1;
        if (mode != 0) req1 = 1'b1;
    endtask

    task automatic flush();
        exp_q.delete();
        ctl_q.delete();
        in_flight = 1'b0;
        rdy_at    = -1;
        stray_at  = -1;
        req0      = 1'b0;
        req1      = 1'b0;
        drop0     = 1'b0;
        drop1     = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge sdram_clk);
            budget++;
        end
        check("drain_in_time", 64'(exp_q.size()), 64'd0);
        if (exp_q.size() != 0) flush();
    endtask

    task automatic gap(input int extra);
        @(posedge sdram_clk);
        @(posedge sdram_clk);
        repeat (extra) @(posedge sdram_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack0"}, 64'(ack0), 64'd0);
        check({tag, "_ack1"}, 64'(ack1), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_timeout_seen"}, 64'(timeout_seen), 64'd0);
        check({tag, "_sdram_rd"}, 64'(sdram_rd), 64'd0);
        check({tag, "_raddr"}, 64'(sdram_raddr), 64'd0);
        check({tag, "_dout"}, 64'(dout), 64'd0);
    endtask

    // SDRAM controller and requester behaviour; all driving happens on the falling edge.
    initial begin : controller
        ctl_t c;
        forever begin
            @(negedge sdram_clk);
            if (drop0) begin req0 = 1'b0; drop0 = 1'b0; end
            if (drop1) begin req1 = 1'b0; drop1 = 1'b0; end
            if (ack0) drop0 = 1'b1;
            if (ack1) drop1 = 1'b1;
            sdram_rd_rdy = 1'b0;
            sdram_dout   = DATA_W'($urandom);
            if (cyc == rdy_at) begin
                sdram_rd_rdy = 1'b1;
                sdram_dout   = rdy_data;
            end
            if (cyc == stray_at) sdram_rd_rdy = 1'b1;
            if (!reset && sdram_rd && ctl_q.size() > 0) begin
                c = ctl_q.pop_front();
                if (c.stray) sdram_rd_rdy = 1'b1;
                if (c.k > 0) begin
                    rdy_at   = cyc + c.k;
                    rdy_data = c.data;
                end
                if (c.to) stray_at = cyc + TIMEOUT + 3;
                // The granted port's address moves after the grant; the latched one must be used.
                if (exp_q.size() > 0) begin
                    if (exp_q[0].port) addr1 = ADDR_W'($urandom);
                    else               addr0 = ADDR_W'($urandom);
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sdram_clk);
            if (!reset) begin
                if (sdram_rd) begin
                    if (exp_q.size() == 0) begin
                        check("strobe_without_request", 64'(sdram_rd), 64'd0);
                    end else begin
                        check("strobe_once", 64'(in_flight), 64'd0);
                        check("strobe_raddr", 64'(sdram_raddr), 64'(exp_q[0].addr));
                        in_flight  = 1'b1;
                        strobe_cyc = cyc;
                    end
                end else if (in_flight && exp_q.size() > 0) begin
                    check("raddr_stable", 64'(sdram_raddr), 64'(exp_q[0].addr));
                end
                if (ack0 || ack1) begin
                    check("ack_exclusive", 64'(ack0 & ack1), 64'd0);
                    if (exp_q.size() == 0) begin
                        check("ack_without_request", 64'(ack0 | ack1), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_port", 64'(ack1), 64'(e.port));
                        check("ack_after_strobe", 64'(in_flight), 64'd1);
                        check("ack_dout", 64'(dout), 64'(e.dout));
                        check("ack_err", 64'(err), 64'(e.err));
                        check("ack_latency", 64'(cyc - strobe_cyc), 64'(e.lat));
                        check("ack_timeout_seen", 64'(timeout_seen), 64'(e.tseen));
                        hold_dout = e.dout;
                        in_flight = 1'b0;
                    end
                end else begin
                    check("dout_hold", 64'(dout), 64'(hold_dout));
                    check("err_without_ack", 64'(err), 64'd0);
                end
            end
        end
    end

    initial begin : stimulus
        int budget;
        int mode;
        logic [DATA_W-1:0] fp_exp;

        #1 reset = 1'b1;
        #2 check_all_zero("reset");
        repeat (3) @(negedge sdram_clk);
        reset = 1'b0;
        gap(0);

        // Contention: grants alternate 0,1,0,1 starting with port 0.
        launch(2, 25'h0000100, 25'h0000200, 2, 2, 16'h1111, 16'h2222, 1'b0, 1'b0);
        drain(); gap(0);
        launch(2, 25'h0000300, 25'h0000400, 2, 2, 16'h3333, 16'h4444, 1'b0, 1'b0);
        drain(); gap(1);
        // Single read, ready 3 cycles after the strobe.
        launch(0, 25'h0001234, 25'h0, 3, 0, 16'hBEEF, 16'h0, 1'b0, 1'b0);
        drain(); gap(1);
        // Timeout on port 1, then a stray ready in IDLE.
        launch(1, 25'h0, 25'h1ABCDEF, 0, 0, 16'h0, 16'h0, 1'b0, 1'b0);
        drain(); gap(2);
        check("timeout_sticky", 64'(timeout_seen), 64'd1);
        // Ready on the watchdog expiry cycle.
        launch(0, 25'h0000042, 25'h0, TIMEOUT, 0, 16'hCAFE, 16'h0, 1'b0, 1'b0);
        drain(); gap(0);
        // Ready during the strobe cycle, then the real one.
        launch(1, 25'h0, 25'h0000777, 1, 0, 16'h7777, 16'h0, 1'b1, 1'b0);
        drain(); gap(0);

        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            launch(mode, ADDR_W'($urandom), ADDR_W'($urandom),
                   int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                   DATA_W'($urandom), DATA_W'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            drain();
            gap(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of WAIT abandons the read.
        launch(0, 25'h0155555, 25'h0, 0, 0, 16'h0, 16'h0, 1'b0, 1'b0);
        budget = 0;
        while (!in_flight && budget < 20) begin
            @(negedge sdram_clk);
            budget++;
        end
        check("rst_strobe_seen", 64'(in_flight), 64'd1);
        @(posedge sdram_clk);
        #3 reset = 1'b1;
        #1 check_all_zero("async_reset");
        flush();
        m_last    = 1'b1;
        m_tseen   = 1'b0;
        m_dout    = '0;
        hold_dout = '0;
        @(negedge sdram_clk);
        reset    = 1'b0;
        stray_at = cyc + 1;
        repeat (6) @(negedge sdram_clk);
        check("rst_no_ack", 64'(exp_q.size()), 64'd0);
        gap(0);
        launch(0, 25'h0002468, 25'h0, 2, 0, 16'h5A5A, 16'h0, 1'b0, 1'b0);
        drain(); gap(0);
        check("rst_timeout_seen_clear", 64'(timeout_seen), 64'd0);

        // Fixed priority: port 0 keeps winning while both requests stay high.
        fp_addr0 = 25'h00ABCDE;
        fp_addr1 = 25'h1F0F0F0;
        fp_req0  = 1'b1;
        fp_req1  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            budget = 0;
            do begin
                @(negedge sdram_clk);
                budget++;
            end while (!fp_sdram_rd && budget < 20);
            check("fp_strobe_seen", 64'(fp_sdram_rd), 64'd1);
            check("fp_raddr", 64'(fp_raddr), 64'(fp_addr0));
            fp_exp = DATA_W'(32'h1000 + n);
            @(negedge sdram_clk);
            @(negedge sdram_clk);
            fp_rdy     = 1'b1;
            fp_sd_dout = fp_exp;
            @(negedge sdram_clk);
            fp_rdy = 1'b0;
            check("fp_ack0", 64'(fp_ack0), 64'd1);
            check("fp_ack1", 64'(fp_ack1), 64'd0);
            check("fp_dout", 64'(fp_dout), 64'(fp_exp));
        end
        fp_req0 = 1'b0;
        fp_req1 = 1'b0;
        repeat (3) @(negedge sdram_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_timeout
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
